// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared AXI constants, fetch FSM encoding and clog2 helper
package vga_pkg;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } fetch_state_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/pp_bank_ram.sv
// rtl/pp_bank_ram.sv - two-bank line storage, one write port and one async read port
module pp_bank_ram
  import vga_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int BURST_LEN  = 32,
  localparam int AW        = clog2(BURST_LEN) + 1
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [AW-1:0]         waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]         raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [2*BURST_LEN];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/pp_line_fetch.sv
// rtl/pp_line_fetch.sv - ping-pong pixel prefetcher: AXI burst fill of one bank, pixel drain of the other
module pp_line_fetch
  import vga_pkg::*;
#(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64,
  parameter int BURST_LEN  = 32,
  parameter int PIX_WIDTH  = 12,
  parameter int PIX_SLOT   = 16
) (
  input  logic                  clk_v,
  input  logic                  resetn_v,
  input  logic                  enable_i,
  input  logic                  frame_sync_i,
  input  logic [ADDR_WIDTH-1:0] base_addr_i,
  input  logic [ADDR_WIDTH-1:0] top_addr_i,
  input  logic                  pix_req_i,
  output logic [PIX_WIDTH-1:0]  pix_o,
  output logic                  pix_valid_o,
  output logic                  underrun_o,
  output logic                  rerr_o,
  input  logic                  clr_i,
  input  logic                  arready_i,
  output logic [ADDR_WIDTH-1:0] araddr_o,
  output logic [7:0]            arlen_o,
  output logic [2:0]            arsize_o,
  output logic [1:0]            arburst_o,
  output logic                  arvalid_o,
  input  logic                  rvalid_i,
  input  logic [DATA_WIDTH-1:0] rdata_i,
  input  logic [1:0]            rresp_i,
  input  logic                  rlast_i,
  output logic                  rready_o
);

  localparam int PPB = DATA_WIDTH / PIX_SLOT;
  localparam int BW  = clog2(BURST_LEN);
  localparam int SW  = (PPB > 1) ? clog2(PPB) : 1;
  localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(BURST_LEN * DATA_WIDTH / 8);
  localparam logic [BW-1:0] BEAT_LAST = BW'(BURST_LEN - 1);
  localparam logic [SW-1:0] SLOT_LAST = SW'(PPB - 1);

  fetch_state_e state_q, state_d;
  logic [ADDR_WIDTH-1:0] araddr_q, araddr_d, next_addr_q, next_addr_d, addr_inc;
  logic arvalid_q, arvalid_d, rready_q, rready_d;
  logic [BW-1:0] beat_cnt_q, beat_cnt_d, word_cnt_q, word_cnt_d;
  logic [SW-1:0] slot_cnt_q, slot_cnt_d;
  logic [1:0] full_q, full_d;
  logic wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d, restart_pend_q, restart_pend_d;
  logic [PIX_WIDTH-1:0] pix_q, pix_d;
  logic pix_valid_q, pix_valid_d, underrun_q, underrun_d, rerr_q, rerr_d;
  logic ram_we, underrun_set, rerr_set;
  logic [DATA_WIDTH-1:0] ram_wdata, ram_rdata;

  pp_bank_ram #(.DATA_WIDTH(DATA_WIDTH), .BURST_LEN(BURST_LEN)) u_ram (
    .clk_i   (clk_v),
    .we_i    (ram_we),
    .waddr_i ({wr_bank_q, beat_cnt_q}),
    .wdata_i (ram_wdata),
    .raddr_i ({rd_bank_q, word_cnt_q}),
    .rdata_o (ram_rdata)
  );

  assign addr_inc  = next_addr_q + STEP;
  assign ram_wdata = (rresp_i != AXI_RESP_OKAY) ? '0 : rdata_i;

  always_comb begin
    state_d        = state_q;
    araddr_d       = araddr_q;
    arvalid_d      = arvalid_q;
    rready_d       = rready_q;
    next_addr_d    = next_addr_q;
    beat_cnt_d     = beat_cnt_q;
    word_cnt_d     = word_cnt_q;
    slot_cnt_d     = slot_cnt_q;
    full_d         = full_q;
    wr_bank_d      = wr_bank_q;
    rd_bank_d      = rd_bank_q;
    restart_pend_d = restart_pend_q;
    pix_d          = pix_q;
    pix_valid_d    = 1'b0;
    ram_we         = 1'b0;
    underrun_set   = 1'b0;
    rerr_set       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (restart_pend_q) begin
          next_addr_d    = base_addr_i;
          full_d         = 2'b00;
          wr_bank_d      = 1'b0;
          rd_bank_d      = 1'b0;
          word_cnt_d     = '0;
          slot_cnt_d     = '0;
          restart_pend_d = 1'b0;
        end else if (enable_i && !full_q[wr_bank_q]) begin
          state_d   = ST_ADDR;
          araddr_d  = next_addr_q;
          arvalid_d = 1'b1;
        end
      end
      ST_ADDR: begin
        if (arready_i) begin
          arvalid_d   = 1'b0;
          rready_d    = 1'b1;
          beat_cnt_d  = '0;
          state_d     = ST_DATA;
          next_addr_d = (addr_inc >= top_addr_i) ? base_addr_i : addr_inc;
        end
      end
      ST_DATA: begin
        if (rvalid_i && rready_q) begin
          ram_we     = 1'b1;
          beat_cnt_d = beat_cnt_q + 1'b1;
          if (rresp_i != AXI_RESP_OKAY) rerr_set = 1'b1;
          if (rlast_i || beat_cnt_q == BEAT_LAST) begin
            rready_d = 1'b0;
            state_d  = ST_IDLE;
            // A burst overlapping a frame restart carries stale-frame data, so it is never published.
            if (!restart_pend_q) begin
              full_d[wr_bank_q] = 1'b1;
              wr_bank_d         = ~wr_bank_q;
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (pix_req_i) begin
      if (full_q[rd_bank_q] && !restart_pend_q) begin
        pix_d       = PIX_WIDTH'(ram_rdata >> (slot_cnt_q * PIX_SLOT));
        pix_valid_d = 1'b1;
        slot_cnt_d  = slot_cnt_q + 1'b1;
        if (slot_cnt_q == SLOT_LAST) begin
          slot_cnt_d = '0;
          word_cnt_d = word_cnt_q + 1'b1;
          if (word_cnt_q == BEAT_LAST) begin
            full_d[rd_bank_q] = 1'b0;
            rd_bank_d         = ~rd_bank_q;
            word_cnt_d        = '0;
          end
        end
      end else begin
        underrun_set = 1'b1;
      end
    end

    if (frame_sync_i) restart_pend_d = 1'b1;
    underrun_d = (underrun_q & ~clr_i) | underrun_set;
    rerr_d     = (rerr_q & ~clr_i) | rerr_set;
  end

  always_ff @(posedge clk_v or negedge resetn_v) begin
    if (!resetn_v) begin
      state_q        <= ST_IDLE;
      araddr_q       <= '0;
      arvalid_q      <= 1'b0;
      rready_q       <= 1'b0;
      next_addr_q    <= '0;
      beat_cnt_q     <= '0;
      word_cnt_q     <= '0;
      slot_cnt_q     <= '0;
      full_q         <= 2'b00;
      wr_bank_q      <= 1'b0;
      rd_bank_q      <= 1'b0;
      restart_pend_q <= 1'b1;
      pix_q          <= '0;
      pix_valid_q    <= 1'b0;
      underrun_q     <= 1'b0;
      rerr_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      araddr_q       <= araddr_d;
      arvalid_q      <= arvalid_d;
      rready_q       <= rready_d;
      next_addr_q    <= next_addr_d;
      beat_cnt_q     <= beat_cnt_d;
      word_cnt_q     <= word_cnt_d;
      slot_cnt_q     <= slot_cnt_d;
      full_q         <= full_d;
      wr_bank_q      <= wr_bank_d;
      rd_bank_q      <= rd_bank_d;
      restart_pend_q <= restart_pend_d;
      pix_q          <= pix_d;
      pix_valid_q    <= pix_valid_d;
      underrun_q     <= underrun_d;
      rerr_q         <= rerr_d;
    end
  end

  assign pix_o       = pix_q;
  assign pix_valid_o = pix_valid_q;
  assign underrun_o  = underrun_q;
  assign rerr_o      = rerr_q;
  assign araddr_o    = araddr_q;
  assign arvalid_o   = arvalid_q;
  assign rready_o    = rready_q;
  assign arlen_o     = 8'(BURST_LEN - 1);
  assign arsize_o    = 3'(clog2(DATA_WIDTH / 8));
  assign arburst_o   = AXI_BURST_INCR;

endmodule

// File: doc/pp_line_fetch.md
Name: pp_line_fetch

Overview:
Parametrised single-clock ping-pong pixel prefetcher for the VGA path. An AXI4 read master fills one bank with INCR bursts from the frame buffer while the VGA control unit drains the other bank pixel by pixel. Bank width, burst length, pixel width and pixel slot size are configurable. Per-bank full/empty tracking, frame restart, underrun detection and response-error detection are included.

Parameters:
ADDR_WIDTH, 64, AXI address width
DATA_WIDTH, 64, AXI data width; one bank word per beat
BURST_LEN, 32, beats per burst = words per bank; power of two, 2..256
PIX_WIDTH, 12, pixel bits delivered to the VGA control unit
PIX_SLOT, 16, bits per pixel slot in a word; DATA_WIDTH/PIX_SLOT is a power of two; PIX_WIDTH <= PIX_SLOT

Ports:
clk_v  in  1  clock for the block and its AXI interface
resetn_v  in  1  asynchronous active-low reset
enable_i  in  1  allows new bursts to be issued
frame_sync_i  in  1  one-cycle pulse; restarts fetching at base_addr_i
base_addr_i  in  ADDR_WIDTH  frame start byte address
top_addr_i  in  ADDR_WIDTH  frame end byte address (exclusive)
pix_req_i  in  1  pixel request from the VGA control unit
pix_o  out  PIX_WIDTH  pixel data
pix_valid_o  out  1  pix_o is valid this cycle
underrun_o  out  1  sticky: a request arrived while the read bank was empty
rerr_o  out  1  sticky: a non-OKAY rresp was received
clr_i  in  1  clears underrun_o and rerr_o
arready_i  in  1  AXI AR ready
araddr_o  out  ADDR_WIDTH  AXI AR address
arlen_o  out  8  equals BURST_LEN-1
arsize_o  out  3  equals log2(DATA_WIDTH/8)
arburst_o  out  2  equals 2'b01 (INCR)
arvalid_o  out  1  AXI AR valid
rvalid_i  in  1  AXI R valid
rdata_i  in  DATA_WIDTH  AXI R data
rresp_i  in  2  AXI R response
rlast_i  in  1  AXI R last
rready_o  out  1  AXI R ready

Behaviour:
- Reset (async, resetn_v low):
  - Outputs: pix_o=0, pix_valid_o=0, underrun_o=0, rerr_o=0, araddr_o=0, arvalid_o=0, rready_o=0.
  - Internal: both bank full flags=0, wr_bank=0, rd_bank=0, all counters=0, next_addr=0, restart_pend=1.
  - arlen_o, arsize_o and arburst_o are constants.
- Derived values: PPB=DATA_WIDTH/PIX_SLOT; STEP=BURST_LEN*DATA_WIDTH/8, computed at ADDR_WIDTH.
- Fetch FSM IDLE -> ADDR -> DATA -> IDLE:
  - IDLE, restart_pend=1: next_addr<=base_addr_i; clear both full flags, wr_bank, rd_bank and the read counters; restart_pend<=0. Stay in IDLE for this cycle.
  - IDLE, otherwise: if enable_i and full[wr_bank]=0, go to ADDR with araddr_o<=next_addr and arvalid_o<=1.
  - ADDR: hold arvalid_o and araddr_o stable until arready_i. On handshake: arvalid_o<=0, rready_o<=1, beat_cnt<=0, go to DATA. Also update next_addr: if next_addr+STEP >= top_addr_i then base_addr_i, else next_addr+STEP.
  - DATA: each rvalid_i&rready_o beat writes bank[wr_bank][beat_cnt] and increments beat_cnt.
    - A beat with rresp_i!=0 is written as all zeros and sets rerr_o.
    - The burst ends on a beat with rlast_i, or with beat_cnt==BURST_LEN-1, whichever comes first.
    - At burst end: rready_o<=0; unless restart_pend, set full[wr_bank] and toggle wr_bank; return to IDLE.
- frame_sync_i: sets restart_pend in any state. The AXI burst in flight is never aborted. Its data is written but the bank is not marked full. The restart is applied in the next IDLE cycle.
- enable_i low: any outstanding burst completes, and no new AR is issued.
- Read side, evaluated every cycle, registered, 1-cycle latency:
  - pix_req_i and full[rd_bank] and no restart_pend:
    - pix_o <= bank[rd_bank][word_cnt][slot_cnt*PIX_SLOT +: PIX_WIDTH]; pix_valid_o<=1.
    - slot_cnt++. Slot 0 is the least significant slot.
    - On slot_cnt==PPB-1: slot_cnt<=0 and word_cnt++.
    - On the last slot of word BURST_LEN-1: full[rd_bank]<=0, toggle rd_bank, word_cnt<=0.
  - pix_req_i with an empty bank or restart_pend: pix_valid_o<=0, pix_o holds its value, underrun_o<=1, and no pointer moves.
  - No request: pix_valid_o<=0, pix_o holds.
- Simultaneous events:
  - Fill completion and drain completion in the same cycle act on different banks; both take effect.
  - clr_i together with a new error or underrun: the set wins.
- Bank storage has no reset; only the full flags guard reads.

Decomposition:
- Shared package vga_pkg holds: AXI_BURST_INCR=2'b01, AXI_RESP_OKAY=2'b00, the fetch FSM state encoding, and a clog2 helper function.
- One sub-module, pp_bank_ram: a 2*BURST_LEN x DATA_WIDTH storage array with one write port and one read port, addressed by {bank, word}.

Test Plan:
- Reset then frame_sync with base=0x1000, top=0x1800 -> first AR has araddr=0x1000, arlen=31, arsize=3, arburst=1. The second AR, issued once bank 1 is empty, has araddr=0x1100.
- Hold arready low for 5 cycles -> arvalid and araddr stay stable; rready stays 0 until the handshake.
- Fill one bank with word k = {4{16'(k)}}, then request 128 pixels back-to-back -> pix_o = k[11:0] four times per word, pix_valid 1 cycle after each request, then rd_bank toggles.
- Request with both banks empty -> pix_valid=0 and underrun_o=1. clr_i -> underrun_o=0.
- rresp=2'b10 on beat 3 -> word 3 reads as zero pixels; rerr_o=1.
- frame_sync mid-burst -> the burst completes, the bank is not marked full, and the next AR uses the current base_addr_i. Address wrap: base=0, top=0x200 -> AR sequence is 0x000, 0x100, 0x000.
